// File: rtl/uartio_pkg.sv
// uartio_pkg: shared constants and types for the uartio serial port.
//   - register address map
//   - STATUS / CTRL bit indices
//   - FSM state enum shared by the TX and RX engines
//   - oversampling constants
package uartio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_DIVLO  = 3'd3;
    localparam logic [2:0] ADDR_DIVHI  = 3'd4;
    localparam logic [2:0] ADDR_RXCNT  = 3'd5;

    localparam int unsigned ST_RXAV   = 0;
    localparam int unsigned ST_THRE   = 1;
    localparam int unsigned ST_TXIDLE = 2;
    localparam int unsigned ST_OVR    = 3;
    localparam int unsigned ST_FERR   = 4;
    localparam int unsigned ST_IRQ    = 7;

    localparam int unsigned CT_RXIE = 0;
    localparam int unsigned CT_TXIE = 1;
    localparam int unsigned CT_LOOP = 2;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uartio_fifo.sv
// uartio_fifo: synchronous receive FIFO.
//   clk, rst (async, active-low)
//   i_push/i_data : write an entry (ignored when full unless popping in the same cycle)
//   i_pop         : drop the head entry (ignored when empty)
//   o_data        : head entry
//   o_full/o_empty/o_count : occupancy, o_count in 0..FIFO_DEPTH
module uartio_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [7:0]    i_data,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    // A pop frees the slot the same cycle, so a full FIFO still accepts a concurrent push.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | i_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/uartio.sv
// uartio: bus-attached 8N1 UART with 16x oversampling baud generator and RX FIFO.
//   clk, rst (async, active-low)
//   AD/DI/DO/rw/cs : register bus (DO is combinational from AD)
//   irq            : registered level interrupt
//   rxd / txd      : serial in (asynchronous, idle high) / serial out (idle high)
// Optional feature: define UARTIO_LOOPBACK_EN to implement CTRL.LOOP (TX line feeds RX,
// txd held high). Without it CTRL bit 2 reads 0 and no loopback mux exists.
module uartio
    import uartio_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd0,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       rxd,
    output logic       txd
);

    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]  LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  MID_TICK  = 4'(MID_SAMPLE - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    logic [15:0] r_div, r_tick_cnt;
    logic [1:0]  r_ie;
    logic [7:0]  r_thr, r_tx_shift, r_rx_shift;
    logic        r_thr_full, r_rxd_s1, r_rxd_s2, r_rx_armed, r_ovr, r_ferr, r_irq;
    logic [3:0]  r_tx_tcnt, r_rx_tcnt;
    logic [2:0]  r_tx_bit, r_rx_bit;
    uart_state_e r_tx_state, w_tx_state_next, r_rx_state, w_rx_state_next;

    logic             w_wr, w_pop, w_tick, w_tx_load, w_tx_line, w_rx_src, w_rx;
    logic             w_rx_sample, w_rx_push, w_rx_ferr, w_full, w_empty, w_loop;
    logic [7:0]       w_fifo_data, w_status;
    logic [CNT_W-1:0] w_count;

    assign w_wr  = cs & ~rw;
    assign w_pop = cs & rw & (AD == ADDR_DATA);

`ifdef UARTIO_LOOPBACK_EN
    logic r_loop;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          r_loop <= 1'b0;
        else if (w_wr && AD == ADDR_CTRL) r_loop <= DI[CT_LOOP];
    end
    assign w_loop   = r_loop;
    assign w_rx_src = r_loop ? w_tx_line : rxd;
    assign txd      = r_loop | w_tx_line;
`else
    assign w_loop   = 1'b0;
    assign w_rx_src = rxd;
    assign txd      = w_tx_line;
`endif

    // Baud tick: a divisor write restarts the count from the new divisor.
    assign w_tick = (r_tick_cnt == 16'd0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= DEFAULT_DIV;
            r_tick_cnt <= DEFAULT_DIV;
        end else if (w_wr && AD == ADDR_DIVLO) begin
            r_div[7:0] <= DI;
            r_tick_cnt <= {r_div[15:8], DI};
        end else if (w_wr && AD == ADDR_DIVHI) begin
            r_div[15:8] <= DI;
            r_tick_cnt  <= {DI, r_div[7:0]};
        end else if (w_tick) begin
            r_tick_cnt <= r_div;
        end else begin
            r_tick_cnt <= r_tick_cnt - 16'd1;
        end
    end

    // ---------------- TX engine ----------------
    assign w_tx_load = (r_tx_state == StIdle) & w_tick & r_thr_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tx_state <= StIdle;
        else      r_tx_state <= w_tx_state_next;
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        unique case (r_tx_state)
            StIdle:  if (w_tx_load) w_tx_state_next = StStart;
            StStart: if (w_tick && r_tx_tcnt == LAST_TICK) w_tx_state_next = StData;
            StData:  if (w_tick && r_tx_tcnt == LAST_TICK && r_tx_bit == LAST_BIT)
                         w_tx_state_next = StStop;
            StStop:  if (w_tick && r_tx_tcnt == LAST_TICK) w_tx_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_tx_line = 1'b1;
        unique case (r_tx_state)
            StIdle:  w_tx_line = 1'b1;
            StStart: w_tx_line = 1'b0;
            StData:  w_tx_line = r_tx_shift[0];
            StStop:  w_tx_line = 1'b1;
        endcase
    end

    // Tick and bit counters wrap naturally, so they are back at 0 on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_thr      <= 8'h00;
            r_thr_full <= 1'b0;
            r_tx_shift <= 8'h00;
            r_tx_tcnt  <= 4'd0;
            r_tx_bit   <= 3'd0;
        end else begin
            if (w_tx_load) begin
                r_tx_shift <= r_thr;
                r_thr_full <= 1'b0;
            end else if (w_tick && r_tx_state != StIdle) begin
                r_tx_tcnt <= r_tx_tcnt + 4'd1;
                if (r_tx_state == StData && r_tx_tcnt == LAST_TICK) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end
            // Writes while the holding register is full are silently dropped.
            if (w_wr && AD == ADDR_DATA && !r_thr_full) begin
                r_thr      <= DI;
                r_thr_full <= 1'b1;
            end
        end
    end

    // ---------------- RX engine ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
        end else begin
            r_rxd_s1 <= w_rx_src;
            r_rxd_s2 <= r_rxd_s1;
        end
    end
    assign w_rx = r_rxd_s2;

    assign w_rx_sample = w_tick & (r_rx_tcnt == LAST_TICK) &
                         ((r_rx_state == StData) | (r_rx_state == StStop));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rx_state <= StIdle;
        else      r_rx_state <= w_rx_state_next;
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        unique case (r_rx_state)
            StIdle:  if (w_tick && !w_rx && r_rx_armed) w_rx_state_next = StStart;
            // Mid-start check: still low means a real start bit, high means a glitch.
            StStart: if (w_tick && r_rx_tcnt == MID_TICK)
                         w_rx_state_next = w_rx ? StIdle : StData;
            StData:  if (w_rx_sample && r_rx_bit == LAST_BIT) w_rx_state_next = StStop;
            StStop:  if (w_rx_sample) w_rx_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_rx_push = 1'b0;
        w_rx_ferr = 1'b0;
        if (r_rx_state == StStop && w_rx_sample) begin
            w_rx_push = w_rx;
            w_rx_ferr = ~w_rx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_tcnt  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_armed <= 1'b1;
        end else begin
            unique case (r_rx_state)
                StIdle: begin
                    r_rx_tcnt <= 4'd0;
                    r_rx_bit  <= 3'd0;
                    if (w_rx) r_rx_armed <= 1'b1;
                end
                StStart: if (w_tick) begin
                    r_rx_tcnt <= (r_rx_tcnt == MID_TICK) ? 4'd0 : r_rx_tcnt + 4'd1;
                end
                StData: begin
                    if (w_tick) r_rx_tcnt <= r_rx_tcnt + 4'd1;
                    if (w_rx_sample) begin
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end
                end
                StStop: begin
                    if (w_tick) r_rx_tcnt <= r_rx_tcnt + 4'd1;
                    // After a framing error, wait for the line to return high.
                    if (w_rx_ferr) r_rx_armed <= 1'b0;
                end
            endcase
        end
    end

    uartio_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_rx_push),
        .i_pop  (w_pop),
        .i_data (r_rx_shift),
        .o_data (w_fifo_data),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    // ---------------- control / status ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ie   <= 2'b00;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && AD == ADDR_CTRL) r_ie <= DI[1:0];
            if (w_wr && AD == ADDR_STATUS) begin
                r_ovr  <= 1'b0;
                r_ferr <= 1'b0;
            end
            // A concurrent pop makes room, so only a push into a full FIFO without pop overflows.
            if (w_rx_push && w_full && !w_pop) r_ovr <= 1'b1;
            if (w_rx_ferr) r_ferr <= 1'b1;
            r_irq <= (r_ie[CT_RXIE] & (~w_empty | r_ovr | r_ferr)) |
                     (r_ie[CT_TXIE] & ~r_thr_full);
        end
    end
    assign irq = r_irq;

    always_comb begin
        w_status            = 8'h00;
        w_status[ST_RXAV]   = ~w_empty;
        w_status[ST_THRE]   = ~r_thr_full;
        w_status[ST_TXIDLE] = ~r_thr_full & (r_tx_state == StIdle);
        w_status[ST_OVR]    = r_ovr;
        w_status[ST_FERR]   = r_ferr;
        w_status[ST_IRQ]    = r_irq;
    end

    always_comb begin
        DO = 8'h00;
        case (AD)
            ADDR_DATA:   DO = w_empty ? 8'h00 : w_fifo_data;
            ADDR_STATUS: DO = w_status;
            ADDR_CTRL:   DO = {5'b00000, w_loop, r_ie};
            ADDR_DIVLO:  DO = r_div[7:0];
            ADDR_DIVHI:  DO = r_div[15:8];
            ADDR_RXCNT:  DO = 8'(w_count);
            default:     DO = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uartio.sv
// tb_uartio: directed self-checking bench for uartio (DIV=0, 8-entry FIFO).
module tb_uartio;

    logic       clk, rst, rw, cs, rxd, irq, txd;
    logic [2:0] AD;
    logic [7:0] DI, DO;
    int         n_checks = 0;
    int         n_pass   = 0;

    uartio #(
        .DEFAULT_DIV(16'd0),
        .FIFO_DEPTH (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .AD (AD),
        .DI (DI),
        .DO (DO),
        .rw (rw),
        .cs (cs),
        .irq(irq),
        .rxd(rxd),
        .txd(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        AD = a; rw = 1'b1; cs = 1'b1;
        #1 d = DO;
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Combinational look at a register without a bus cycle (no pop side effect).
    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        AD = a;
        #1 d = DO;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame at DIV=0: 16 clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clk(16);
        end
        rxd = stop;
        wait_clk(16);
        rxd = 1'b1;
    endtask

    logic [7:0] v;
    logic [7:0] bits;
    logic       saw_low;

    initial begin
        rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00; rxd = 1'b1;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(2);

        // Reset state
        peek(3'd1, v); check("rst_status", v, 8'h06);
        peek(3'd2, v); check("rst_ctrl", v, 8'h00);
        peek(3'd5, v); check("rst_rxcnt", v, 8'h00);
        peek(3'd6, v); check("rst_addr6", v, 8'h00);
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);

        // Divisor readback, then back to 0
        bus_wr(3'd3, 8'h12);
        peek(3'd3, v); check("divlo_rb", v, 8'h12);
        bus_wr(3'd3, 8'h00);

        // TX of 8'hA5
        bus_wr(3'd0, 8'hA5);
        peek(3'd1, v); check("tx_thre_busy", v, 8'h00);
        check("tx_txd_pre", txd, 1'b1);
        wait_clk(1);
        check("tx_start_edge", txd, 1'b0);
        peek(3'd1, v); check("tx_thre_after_load", v, 8'h02);
        bus_wr(3'd0, 8'hFF);  // accepted into now-empty holding register mid-frame? no: THRE=1
        wait_clk(6);          // now at mid start bit (8 clocks after start edge)
        check("tx_start_mid", txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wait_clk(16);
            bits[i] = txd;
        end
        check("tx_data_bits", bits, 8'hA5);
        wait_clk(16);
        check("tx_stop", txd, 1'b1);
        // Second byte (8'hFF) follows: start bit after first stop
        wait_clk(16);
        check("tx_second_start", txd, 1'b0);
        wait_clk(170);
        peek(3'd1, v); check("tx_idle_status", v, 8'h06);

        // TX interrupt: TXIE with THRE=1
        bus_wr(3'd2, 8'h02);
        wait_clk(1);
        check("txie_irq", irq, 1'b1);
        bus_wr(3'd2, 8'h00);
        wait_clk(1);
        check("txie_off_irq", irq, 1'b0);

        // RX of 8'h3C with RXIE
        bus_wr(3'd2, 8'h01);
        peek(3'd2, v); check("ctrl_rxie", v, 8'h01);
        send_frame(8'h3C, 1'b1);
        wait_clk(4);
        peek(3'd5, v); check("rx_cnt1", v, 8'h01);
        check("rx_irq", irq, 1'b1);
        bus_rd(3'd0, v); check("rx_data", v, 8'h3C);
        peek(3'd5, v); check("rx_cnt0", v, 8'h00);
        check("rx_irq_lag", irq, 1'b1);
        wait_clk(1);
        check("rx_irq_drop", irq, 1'b0);

        // Overrun: 9 frames, FIFO keeps the first 8
        for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1);
        wait_clk(4);
        peek(3'd5, v); check("ovr_cnt", v, 8'h08);
        peek(3'd1, v); check("ovr_flag", v[3], 1'b1);
        bus_wr(3'd1, 8'h00);
        peek(3'd1, v); check("ovr_clear", v[3], 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus_rd(3'd0, v);
            check($sformatf("ovr_pop%0d", i), v, 8'(8'h10 + i));
        end
        peek(3'd5, v); check("ovr_drained", v, 8'h00);
        bus_rd(3'd0, v); check("empty_pop_data", v, 8'h00);
        peek(3'd5, v); check("empty_pop_cnt", v, 8'h00);

        // Framing error, then recovery
        bus_wr(3'd2, 8'h00);
        send_frame(8'h55, 1'b0);
        wait_clk(4);
        peek(3'd1, v); check("ferr_flag", v[4], 1'b1);
        peek(3'd5, v); check("ferr_cnt", v, 8'h00);
        bus_wr(3'd1, 8'h00);
        peek(3'd1, v); check("ferr_clear", v[4], 1'b0);
        send_frame(8'h81, 1'b1);
        wait_clk(4);
        bus_rd(3'd0, v); check("ferr_recover", v, 8'h81);

        // Glitch rejection: 4-clock low pulse
        rxd = 1'b0;
        wait_clk(4);
        rxd = 1'b1;
        wait_clk(200);
        peek(3'd5, v); check("glitch_cnt", v, 8'h00);
        peek(3'd1, v); check("glitch_flags", v & 8'h18, 8'h00);

`ifdef UARTIO_LOOPBACK_EN
        bus_wr(3'd2, 8'h04);
        peek(3'd2, v); check("loop_ctrl", v, 8'h04);
        bus_wr(3'd0, 8'h5A);
        saw_low = 1'b0;
        repeat (180) begin
            @(negedge clk);
            if (!txd) saw_low = 1'b1;
        end
        check("loop_txd_high", saw_low, 1'b0);
        peek(3'd5, v); check("loop_cnt", v, 8'h01);
        bus_rd(3'd0, v); check("loop_data", v, 8'h5A);
        bus_wr(3'd2, 8'h00);
`else
        bus_wr(3'd2, 8'h04);
        peek(3'd2, v); check("noloop_ctrl", v, 8'h00);
        saw_low = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
